// File: rtl/dma_host_pkg.sv
// Shared definitions for the DMA host programmer: bus command codes, DMA
// register map, status/control bit positions and the sequencer state encoding.
package dma_host_pkg;

    localparam logic [2:0] CMD_IDLE = 3'b000;
    localparam logic [2:0] CMD_RD   = 3'b001;
    localparam logic [2:0] CMD_WR   = 3'b010;

    typedef logic [2:0] reg_idx_t;
    localparam reg_idx_t REG_STATUS = 3'd0;
    localparam reg_idx_t REG_SRC    = 3'd1;
    localparam reg_idx_t REG_DST    = 3'd2;
    localparam reg_idx_t REG_LEN    = 3'd3;
    localparam reg_idx_t REG_RSVD4  = 3'd4;
    localparam reg_idx_t REG_RSVD5  = 3'd5;
    localparam reg_idx_t REG_CTRL   = 3'd6;
    localparam reg_idx_t REG_RSVD7  = 3'd7;

    localparam int ST_DONE = 0;
    localparam int ST_BUSY = 1;
    localparam int ST_REOP = 2;
    localparam int ST_WEOP = 3;
    localparam int ST_LEN  = 4;

    localparam int CT_BYTE = 0;
    localparam int CT_HW   = 1;
    localparam int CT_WORD = 2;
    localparam int CT_GO   = 3;
    localparam int CT_IEN  = 4;
    localparam int CT_REEN = 5;
    localparam int CT_WEEN = 6;
    localparam int CT_LEEN = 7;
    localparam int CT_RCON = 8;
    localparam int CT_WCON = 9;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_SRC,
        S_WR_DST,
        S_WR_LEN,
        S_CLR_STAT,
        S_WR_CTRL,
        S_POLL_RD,
        S_POLL_WAIT,
        S_GAP,
        S_STOP,
        S_CPL
    } state_t;

    // Transfer size must select exactly one of byte / half-word / word.
    function automatic logic size_onehot(input logic [2:0] sz);
        return (sz == 3'b001) || (sz == 3'b010) || (sz == 3'b100);
    endfunction

endpackage

// File: rtl/dma_host_programmer_if.sv
// Descriptor handshake, DMA register bus and completion signals of the host
// programmer; master = programmer side, slave = sequencer/DMA side.
interface dma_host_programmer_if #(
    parameter int padd_size = 24,
    parameter int data_size = 32,
    parameter int cmd_size  = 3
);
    logic                 req_valid;
    logic                 req_ready;
    logic [data_size-1:0] req_src;
    logic [data_size-1:0] req_dst;
    logic [data_size-1:0] req_len;
    logic [9:0]           req_ctrl;

    logic [cmd_size-1:0]  dma_host_cmd;
    logic [padd_size-1:0] dma_host_addr;
    logic [data_size-1:0] dma_host_datain;
    logic [data_size-1:0] dma_host_dataout;

    logic                 cpl_valid;
    logic                 cpl_err;
    logic                 cpl_timeout;
    logic [data_size-1:0] cpl_status;
    logic                 busy;

    modport master (
        input  req_valid, req_src, req_dst, req_len, req_ctrl, dma_host_dataout,
        output req_ready, dma_host_cmd, dma_host_addr, dma_host_datain,
               cpl_valid, cpl_err, cpl_timeout, cpl_status, busy
    );

    modport slave (
        output req_valid, req_src, req_dst, req_len, req_ctrl, dma_host_dataout,
        input  req_ready, dma_host_cmd, dma_host_addr, dma_host_datain,
               cpl_valid, cpl_err, cpl_timeout, cpl_status, busy
    );
endinterface

// File: rtl/dma_poll_timer.sv
// Poll pacing: gap down-counter between status reads and, with
// DMA_HOST_TIMEOUT_EN defined, a saturating poll timeout counter.
module dma_poll_timer #(
    parameter int POLL_GAP       = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk0,
    input  logic reset,
    input  logic gap_load,
    input  logic tmo_clear,
    input  logic tmo_run,
    output logic gap_expired,
    output logic timeout
);
    localparam int GW       = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam int GAP_INIT = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;

    logic [GW-1:0] gap_cnt;

    // Loaded on the sample cycle so the gap state lasts exactly POLL_GAP cycles.
    always_ff @(posedge clk0) begin
        if (reset)
            gap_cnt <= '0;
        else if (gap_load)
            gap_cnt <= GW'(GAP_INIT);
        else if (gap_cnt != '0)
            gap_cnt <= gap_cnt - GW'(1);
    end

    assign gap_expired = (gap_cnt == '0);

`ifdef DMA_HOST_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk0) begin
        if (reset || tmo_clear)
            tmo_cnt <= '0;
        else if (tmo_run && !timeout)
            tmo_cnt <= tmo_cnt + TW'(1);
    end

    assign timeout = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_tmo;
    assign unused_tmo = ^{tmo_clear, tmo_run};
    assign timeout    = 1'b0;
`endif

endmodule

// File: rtl/dma_host_programmer.sv
// Programs one DMA descriptor over the register bus, polls status until done,
// stops the channel and reports completion. Poll timeout: DMA_HOST_TIMEOUT_EN.
module dma_host_programmer
    import dma_host_pkg::*;
#(
    parameter int                   padd_size      = 24,
    parameter int                   data_size      = 32,
    parameter int                   cmd_size       = 3,
    parameter logic [padd_size-1:0] DMA_BASE       = 24'h080000,
    parameter int                   POLL_GAP       = 4,
    parameter int                   TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk0,
    input  logic                   reset,
    dma_host_programmer_if.master  bus
);
    localparam logic [9:0] GO_MASK = 10'b1 << CT_GO;

    state_t               state;
    logic [data_size-1:0] dst_q;
    logic [data_size-1:0] len_q;
    logic [9:0]           ctrl_q;
    logic                 timed_out;

    logic gap_load, tmo_clear, tmo_run, gap_expired, tmo_hit;

    function automatic logic [padd_size-1:0] reg_addr(input reg_idx_t idx);
        return DMA_BASE + padd_size'(idx);
    endfunction

    assign gap_load  = (state == S_POLL_WAIT);
    assign tmo_clear = (state == S_IDLE);
    assign tmo_run   = (state == S_POLL_RD) || (state == S_POLL_WAIT) || (state == S_GAP);

    dma_poll_timer #(
        .POLL_GAP       (POLL_GAP),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk0        (clk0),
        .reset       (reset),
        .gap_load    (gap_load),
        .tmo_clear   (tmo_clear),
        .tmo_run     (tmo_run),
        .gap_expired (gap_expired),
        .timeout     (tmo_hit)
    );

    // Bus outputs describe the access of the state being entered, so every
    // access is visible for exactly the one cycle that state is occupied.
    always_ff @(posedge clk0) begin
        if (reset) begin
            state               <= S_IDLE;
            dst_q               <= '0;
            len_q               <= '0;
            ctrl_q              <= '0;
            timed_out           <= 1'b0;
            bus.req_ready       <= 1'b1;
            bus.busy            <= 1'b0;
            bus.dma_host_cmd    <= cmd_size'(CMD_IDLE);
            bus.dma_host_addr   <= '0;
            bus.dma_host_datain <= '0;
            bus.cpl_valid       <= 1'b0;
            bus.cpl_err         <= 1'b0;
            bus.cpl_timeout     <= 1'b0;
            bus.cpl_status      <= '0;
        end else begin
            bus.dma_host_cmd <= cmd_size'(CMD_IDLE);
            bus.cpl_valid    <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        dst_q         <= bus.req_dst;
                        len_q         <= bus.req_len;
                        ctrl_q        <= bus.req_ctrl;
                        timed_out     <= 1'b0;
                        bus.req_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        if (bus.req_len == '0 || !size_onehot(bus.req_ctrl[2:0])) begin
                            state           <= S_CPL;
                            bus.cpl_valid   <= 1'b1;
                            bus.cpl_err     <= 1'b1;
                            bus.cpl_timeout <= 1'b0;
                        end else begin
                            // Source goes straight onto the bus; datain holds it.
                            state               <= S_WR_SRC;
                            bus.dma_host_cmd    <= cmd_size'(CMD_WR);
                            bus.dma_host_addr   <= reg_addr(REG_SRC);
                            bus.dma_host_datain <= bus.req_src;
                        end
                    end
                end
                S_WR_SRC: begin
                    state               <= S_WR_DST;
                    bus.dma_host_cmd    <= cmd_size'(CMD_WR);
                    bus.dma_host_addr   <= reg_addr(REG_DST);
                    bus.dma_host_datain <= dst_q;
                end
                S_WR_DST: begin
                    state               <= S_WR_LEN;
                    bus.dma_host_cmd    <= cmd_size'(CMD_WR);
                    bus.dma_host_addr   <= reg_addr(REG_LEN);
                    bus.dma_host_datain <= len_q;
                end
                S_WR_LEN: begin
                    state               <= S_CLR_STAT;
                    bus.dma_host_cmd    <= cmd_size'(CMD_WR);
                    bus.dma_host_addr   <= reg_addr(REG_STATUS);
                    bus.dma_host_datain <= '0;
                end
                S_CLR_STAT: begin
                    state               <= S_WR_CTRL;
                    bus.dma_host_cmd    <= cmd_size'(CMD_WR);
                    bus.dma_host_addr   <= reg_addr(REG_CTRL);
                    bus.dma_host_datain <= data_size'(ctrl_q | GO_MASK);
                end
                S_WR_CTRL: begin
                    state             <= S_POLL_RD;
                    bus.dma_host_cmd  <= cmd_size'(CMD_RD);
                    bus.dma_host_addr <= reg_addr(REG_STATUS);
                end
                S_POLL_RD: begin
                    if (tmo_hit) begin
                        state               <= S_STOP;
                        timed_out           <= 1'b1;
                        bus.dma_host_cmd    <= cmd_size'(CMD_WR);
                        bus.dma_host_addr   <= reg_addr(REG_CTRL);
                        bus.dma_host_datain <= data_size'(ctrl_q & ~GO_MASK);
                    end else begin
                        state <= S_POLL_WAIT;
                    end
                end
                S_POLL_WAIT: begin
                    bus.cpl_status <= bus.dma_host_dataout;
                    if (bus.dma_host_dataout[ST_DONE] || tmo_hit) begin
                        state               <= S_STOP;
                        timed_out           <= !bus.dma_host_dataout[ST_DONE];
                        bus.dma_host_cmd    <= cmd_size'(CMD_WR);
                        bus.dma_host_addr   <= reg_addr(REG_CTRL);
                        bus.dma_host_datain <= data_size'(ctrl_q & ~GO_MASK);
                    end else if (POLL_GAP == 0) begin
                        state             <= S_POLL_RD;
                        bus.dma_host_cmd  <= cmd_size'(CMD_RD);
                        bus.dma_host_addr <= reg_addr(REG_STATUS);
                    end else begin
                        state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (tmo_hit) begin
                        state               <= S_STOP;
                        timed_out           <= 1'b1;
                        bus.dma_host_cmd    <= cmd_size'(CMD_WR);
                        bus.dma_host_addr   <= reg_addr(REG_CTRL);
                        bus.dma_host_datain <= data_size'(ctrl_q & ~GO_MASK);
                    end else if (gap_expired) begin
                        state             <= S_POLL_RD;
                        bus.dma_host_cmd  <= cmd_size'(CMD_RD);
                        bus.dma_host_addr <= reg_addr(REG_STATUS);
                    end
                end
                S_STOP: begin
                    state           <= S_CPL;
                    bus.cpl_valid   <= 1'b1;
                    bus.cpl_err     <= timed_out;
                    bus.cpl_timeout <= timed_out;
                end
                S_CPL: begin
                    state         <= S_IDLE;
                    bus.req_ready <= 1'b1;
                    bus.busy      <= 1'b0;
                end
                default: begin
                    state         <= S_IDLE;
                    bus.req_ready <= 1'b1;
                    bus.busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_host_programmer.sv
// Scoreboard bench: directed descriptors push expected bus accesses and
// completions; a negedge monitor pops and compares whatever the DUT presents.
module tb_dma_host_programmer;
    localparam logic [23:0] BASE      = 24'h080000;
    localparam logic [2:0]  RD        = 3'b001;
    localparam logic [2:0]  WR        = 3'b010;
    localparam logic [31:0] DONE_WORD = 32'h0000_000D;
    localparam logic [31:0] BUSY_WORD = 32'h0000_0002;

    typedef struct {
        int          cyc;
        logic [2:0]  cmd;
        logic [23:0] addr;
        logic [31:0] data;
    } bus_exp_t;

    typedef struct {
        int          cyc;
        logic        err;
        logic        tmo;
        logic [31:0] status;
    } cpl_exp_t;

    bus_exp_t bq[$];
    cpl_exp_t cq[$];

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   done_on  = 0;
    int   polls    = 0;
    logic clk0     = 1'b0;
    logic reset    = 1'b1;

    dma_host_programmer_if #(.padd_size(24), .data_size(32), .cmd_size(3)) bus ();

    dma_host_programmer #(
        .padd_size      (24),
        .data_size      (32),
        .cmd_size       (3),
        .DMA_BASE       (24'h080000),
        .POLL_GAP       (4),
        .TIMEOUT_CYCLES (32)
    ) dut (
        .clk0  (clk0),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk0 = ~clk0;

    always @(posedge clk0) cyc <= cyc + 1;

    // DMA status model: read data appears the cycle after the read command.
    always @(posedge clk0) begin
        if (bus.req_valid && bus.req_ready) begin
            polls = 0;
        end else if (bus.dma_host_cmd == RD) begin
            polls = polls + 1;
            bus.dma_host_dataout <= (done_on != 0 && polls >= done_on) ? DONE_WORD : BUSY_WORD;
        end
    end

    always @(negedge clk0) begin : monitor
        bus_exp_t be;
        cpl_exp_t ce;
        if (!reset && bus.dma_host_cmd != 3'b000) begin
            checks++;
            if (bq.size() == 0) begin
                failures++;
                $display("FAIL bus_unexpected cyc=%0d cmd=%b addr=%h data=%h",
                         cyc, bus.dma_host_cmd, bus.dma_host_addr, bus.dma_host_datain);
            end else begin
                be = bq.pop_front();
                if (cyc != be.cyc || bus.dma_host_cmd != be.cmd || bus.dma_host_addr != be.addr ||
                    (be.cmd == WR && bus.dma_host_datain != be.data)) begin
                    failures++;
                    $display("FAIL bus_access got cyc=%0d cmd=%b addr=%h data=%h want cyc=%0d cmd=%b addr=%h data=%h",
                             cyc, bus.dma_host_cmd, bus.dma_host_addr, bus.dma_host_datain,
                             be.cyc, be.cmd, be.addr, be.data);
                end
            end
        end
        if (!reset && bus.cpl_valid) begin
            checks++;
            if (cq.size() == 0) begin
                failures++;
                $display("FAIL cpl_unexpected cyc=%0d err=%b tmo=%b status=%h",
                         cyc, bus.cpl_err, bus.cpl_timeout, bus.cpl_status);
            end else begin
                ce = cq.pop_front();
                if (cyc != ce.cyc || bus.cpl_err != ce.err || bus.cpl_timeout != ce.tmo ||
                    bus.cpl_status != ce.status) begin
                    failures++;
                    $display("FAIL completion got cyc=%0d err=%b tmo=%b status=%h want cyc=%0d err=%b tmo=%b status=%h",
                             cyc, bus.cpl_err, bus.cpl_timeout, bus.cpl_status,
                             ce.cyc, ce.err, ce.tmo, ce.status);
                end
            end
        end
    end

    task automatic push_bus(input int c, input logic [2:0] cmd, input logic [23:0] a, input logic [31:0] d);
        bus_exp_t e;
        e.cyc = c; e.cmd = cmd; e.addr = a; e.data = d;
        bq.push_back(e);
    endtask

    task automatic push_cpl(input int c, input logic err, input logic tmo, input logic [31:0] st);
        cpl_exp_t e;
        e.cyc = c; e.err = err; e.tmo = tmo; e.status = st;
        cq.push_back(e);
    endtask

    // The five setup writes, go bit set in the control write.
    task automatic push_setup(input int b, input logic [31:0] s, input logic [31:0] d,
                              input logic [31:0] l, input logic [31:0] ctrl_go);
        push_bus(b + 1, WR, BASE + 24'd1, s);
        push_bus(b + 2, WR, BASE + 24'd2, d);
        push_bus(b + 3, WR, BASE + 24'd3, l);
        push_bus(b + 4, WR, BASE + 24'd0, 32'h0);
        push_bus(b + 5, WR, BASE + 24'd6, ctrl_go);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic accept(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                          input logic [9:0] c, output int base);
        int n;
        n = 0;
        @(negedge clk0);
        while (bus.req_ready !== 1'b1 && n < 100) begin
            @(negedge clk0);
            n++;
        end
        check("req_ready_before_accept", {31'b0, bus.req_ready}, 32'h1);
        bus.req_src   = s;
        bus.req_dst   = d;
        bus.req_len   = l;
        bus.req_ctrl  = c;
        bus.req_valid = 1'b1;
        @(posedge clk0);
        #1;
        base = cyc - 1;
        bus.req_valid = 1'b0;
    endtask

    // Waits for the scoreboard to empty, then expects an idle programmer.
    task automatic drain(input string name);
        int n;
        n = 0;
        while ((bq.size() != 0 || cq.size() != 0) && n < 300) begin
            @(negedge clk0);
            #1;
            n++;
        end
        checks++;
        if (bq.size() != 0 || cq.size() != 0) begin
            failures++;
            $display("FAIL %s_drain pending bus=%0d cpl=%0d want 0 0", name, bq.size(), cq.size());
        end
        bq.delete();
        cq.delete();
        @(negedge clk0);
        check({name, "_ready_after"}, {31'b0, bus.req_ready}, 32'h1);
        check({name, "_busy_after"}, {31'b0, bus.busy}, 32'h0);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int b;
        bus.req_valid        = 1'b0;
        bus.req_src          = '0;
        bus.req_dst          = '0;
        bus.req_len          = '0;
        bus.req_ctrl         = '0;
        bus.dma_host_dataout = '0;

        repeat (3) @(posedge clk0);
        @(negedge clk0);
        check("rst_cmd", {29'b0, bus.dma_host_cmd}, 32'h0);
        check("rst_addr", {8'b0, bus.dma_host_addr}, 32'h0);
        check("rst_datain", bus.dma_host_datain, 32'h0);
        check("rst_ready", {31'b0, bus.req_ready}, 32'h1);
        check("rst_busy", {31'b0, bus.busy}, 32'h0);
        check("rst_cpl", {29'b0, bus.cpl_valid, bus.cpl_err, bus.cpl_timeout}, 32'h0);
        check("rst_status", bus.cpl_status, 32'h0);
        reset = 1'b0;

        // Done on first poll: minimum latency.
        done_on = 1;
        accept(32'h100, 32'h200, 32'h40, 10'h004, b);
        push_setup(b, 32'h100, 32'h200, 32'h40, 32'h00C);
        push_bus(b + 6, RD, BASE, 32'h0);
        push_bus(b + 8, WR, BASE + 24'd6, 32'h004);
        push_cpl(b + 9, 1'b0, 1'b0, DONE_WORD);
        drain("first_poll");

        // Done on third poll, reads POLL_GAP+2 cycles apart.
        done_on = 3;
        accept(32'h1000, 32'h2000, 32'h80, 10'h062, b);
        push_setup(b, 32'h1000, 32'h2000, 32'h80, 32'h06A);
        push_bus(b + 6, RD, BASE, 32'h0);
        push_bus(b + 12, RD, BASE, 32'h0);
        push_bus(b + 18, RD, BASE, 32'h0);
        push_bus(b + 20, WR, BASE + 24'd6, 32'h062);
        push_cpl(b + 21, 1'b0, 1'b0, DONE_WORD);
        drain("third_poll");

        // Rejects: no bus traffic, completion one cycle after acceptance, status held.
        accept(32'h100, 32'h200, 32'h0, 10'h004, b);
        push_cpl(b + 1, 1'b1, 1'b0, DONE_WORD);
        drain("len_zero");

        accept(32'h100, 32'h200, 32'h10, 10'h003, b);
        push_cpl(b + 1, 1'b1, 1'b0, DONE_WORD);
        drain("ctrl_two_sizes");

        accept(32'h100, 32'h200, 32'h10, 10'h000, b);
        push_cpl(b + 1, 1'b1, 1'b0, DONE_WORD);
        drain("ctrl_no_size");

        // Reset during cycle 3: three writes seen, then nothing.
        done_on = 1;
        accept(32'h300, 32'h400, 32'h20, 10'h001, b);
        push_bus(b + 1, WR, BASE + 24'd1, 32'h300);
        push_bus(b + 2, WR, BASE + 24'd2, 32'h400);
        push_bus(b + 3, WR, BASE + 24'd3, 32'h20);
        while (cyc < b + 3) @(negedge clk0);
        #1;
        reset = 1'b1;
        @(posedge clk0);
        #1;
        reset = 1'b0;
        check("midrst_cmd", {29'b0, bus.dma_host_cmd}, 32'h0);
        check("midrst_ready", {31'b0, bus.req_ready}, 32'h1);
        check("midrst_busy", {31'b0, bus.busy}, 32'h0);
        check("midrst_pending", bq.size(), 32'h0);
        repeat (4) @(negedge clk0);
        check("midrst_quiet_cmd", {29'b0, bus.dma_host_cmd}, 32'h0);

        // Following descriptor runs normally, done on second poll.
        done_on = 2;
        accept(32'h500, 32'h600, 32'h4, 10'h001, b);
        push_setup(b, 32'h500, 32'h600, 32'h4, 32'h009);
        push_bus(b + 6, RD, BASE, 32'h0);
        push_bus(b + 12, RD, BASE, 32'h0);
        push_bus(b + 14, WR, BASE + 24'd6, 32'h001);
        push_cpl(b + 15, 1'b0, 1'b0, DONE_WORD);
        drain("after_reset");

`ifdef DMA_HOST_TIMEOUT_EN
        // Never done: timeout after 32 polling cycles, six reads then stop.
        done_on = 0;
        accept(32'h700, 32'h800, 32'h100, 10'h0F4, b);
        push_setup(b, 32'h700, 32'h800, 32'h100, 32'h0FC);
        for (int k = 0; k < 6; k++) push_bus(b + 6 + 6 * k, RD, BASE, 32'h0);
        push_bus(b + 38, WR, BASE + 24'd6, 32'h0F4);
        push_cpl(b + 39, 1'b1, 1'b1, BUSY_WORD);
        drain("timeout");
`endif

        repeat (2) @(negedge clk0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
